cpu_core_param: RTL and testbench
=================================

# cpu_core_param

Parametrised multi-cycle accumulator CPU core, the next generation of the 8-bit/4-bit-address accumulator machine. Data and address widths are parameters. It adds a ready/request memory handshake with wait-state support, indirect addressing, control transfer (JMP, JZ), SUB, and an explicit HALT state. It sits between the testbench or SoC memory model and the shared register/ALU primitives, with one synchronous memory port used for both fetch and data.

## Interface
Parameters:
- DW, 8, data/instruction width; must satisfy DW >= AW+4
- AW, 4, address width; PC/AR width; memory depth 2^AW

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_rdata  in  DW  read data, valid in the cycle mem_ready is high
- mem_ready  in  1  completes the pending request at this edge; ignored while mem_req low
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  AW  request address (driven from AR)
- mem_wdata  out  DW  write data (driven from AC)
- halted  out  1  high while in HALT
- pc_out  out  AW  debug view of PC
- ac_out  out  DW  debug view of AC
- e_out  out  1  debug view of E (carry) flag

## Operation
- Instruction format: bit DW-1 = I (indirect); bits DW-2..DW-4 = opcode; bits AW-1..0 = address; remaining bits ignored.
- Opcodes:
  - 0 AND: AC &= M
  - 1 ADD: {E,AC} = AC+M
  - 2 SUB: {E,AC} = AC+~M+1, so E=1 means no borrow
  - 3 LDA: AC = M
  - 4 STA: M = AC
  - 5 JMP: PC = EA
  - 6 JZ: PC = EA if AC==0, otherwise no effect
  - 7 HLT
- EA is the effective address. M is memory at EA.
- E changes only on ADD and SUB.
- FSM states and transitions:
  - F_ADDR: AR<=PC.
  - FETCH: read request at AR. On completion, IR<=mem_rdata and PC<=PC+1 (mod 2^AW).
  - DECODE: AR<=IR[AW-1:0]. Next state is INDIR if I=1, otherwise it depends on the opcode: HALT for HLT, EXEC_J for JMP/JZ, STORE for STA, READ for the rest.
  - INDIR: read request at AR. On completion, AR<=mem_rdata[AW-1:0], then go to the opcode target. The I bit is ignored for HLT.
  - READ: read request. On completion, DR<=mem_rdata.
  - ALU: AC (and E) updated, then F_ADDR.
  - STORE: write request of AC. On completion, go to F_ADDR.
  - EXEC_J: PC update, then F_ADDR.
  - HALT: absorbing state; leave only via reset.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable from request assertion until the edge where mem_req&&mem_ready. Unlimited wait states are allowed.
  - mem_req deasserts in non-memory states.
  - mem_req may be high in back-to-back cycles only across distinct states.
- Reset:
  - All outputs and registers (PC, AR, IR, DR, AC, E) reset to 0. State resets to F_ADDR.
  - Reset mid-transaction abandons the request; mem_req is 0 the cycle after the reset edge.

## Timing
- With mem_ready tied high, cycles per instruction:
  - AND/ADD/SUB/LDA: 5
  - STA: 4
  - JMP/JZ: 4
  - HLT: 3, after which halted is high
  - indirect: +1
- Each wait cycle adds 1 cycle to the state it occurs in.
- halted is registered: high the cycle after entering HALT, held until reset.
- PC wrap: fetch at address 2^AW-1 sets PC=0.

## Structure
- Package cpu_param_pkg holds:
  - opcode localparams/enum: OP_AND..OP_HLT
  - state enum
  - instruction field position functions of DW/AW
- Sub-module cpu_alu (combinational, parameter DW): inputs AC, DR, opcode; outputs result and carry.
- The FSM, registers and handshake stay in cpu_core_param.

## Test plan
All programs use DW=8, AW=4.
- Basic program, ready tied high:
  - mem: [0]=0x38, [1]=0x19, [2]=0x4A, [3]=0x70, [8]=0x05, [9]=0x07
  - Required: mem[A]=0x0C; halted high 17 cycles after reset release; pc_out=4.
- ADD overflow and SUB borrow:
  - 0xFF+0x01 -> AC=0x00, E=1
  - 0x03 SUB 0x05 -> AC=0xFE, E=0
- Indirect load:
  - [0]=0xBC, [C]=0x0D, [D]=0x04
  - Required: AC=0x04; instruction takes 6 cycles.
- JZ:
  - With AC=0, JZ 6 -> next fetch at 6.
  - With AC=0x01, JZ 6 -> next fetch at PC+1. JMP F followed by fetch at F wraps PC to 0.
- Wait states:
  - Drop mem_ready for 3 cycles during the STA write.
  - Required: mem_addr, mem_wdata and mem_we stable throughout; exactly one write occurs; instruction takes 7 cycles.
- Reset mid-READ with mem_ready low:
  - Required: the next cycle has mem_req=0 and all outputs 0; the program restarts at PC=0.

Source files
------------

// File: rtl/cpu_core_param_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes, FSM states,
// instruction field positions and the opcode-to-state dispatch.
package cpu_param_pkg;

    typedef enum logic [2:0] {
        OP_AND, OP_ADD, OP_SUB, OP_LDA, OP_STA, OP_JMP, OP_JZ, OP_HLT
    } opcode_t;

    typedef enum logic [3:0] {
        F_ADDR, FETCH, DECODE, INDIR, READ, ALU, STORE, EXEC_J, HALT
    } state_t;

    // Indirect flag sits in the MSB; the 3-bit opcode sits directly below it.
    function automatic int unsigned ind_bit(input int unsigned dw);
        return dw - 1;
    endfunction

    function automatic int unsigned op_lsb(input int unsigned dw);
        return dw - 4;
    endfunction

    function automatic state_t op_target(input opcode_t op);
        case (op)
            OP_HLT:        return HALT;
            OP_JMP, OP_JZ: return EXEC_J;
            OP_STA:        return STORE;
            default:       return READ;
        endcase
    endfunction

endpackage

// File: rtl/cpu_core_param_if.sv
// Single synchronous memory port shared by instruction fetch and data access.
interface cpu_core_param_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    // Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and holds all
    // of them stable until a rising edge where mem_req && mem_ready; that edge completes
    // the transfer (read data is sampled from mem_rdata in that same cycle). mem_ready is
    // ignored while mem_req is low, and any number of wait cycles is allowed.
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/cpu_core_param_alu.sv
// Combinational accumulator ALU; carry is only meaningful for ADD and SUB.
module cpu_alu
    import cpu_param_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] ac,
    input  logic [DW-1:0] dr,
    input  opcode_t       op,
    output logic [DW-1:0] result,
    output logic          carry
);
    localparam logic [DW:0] ONE = 1;

    logic [DW:0] sum;

    always_comb begin
        sum    = '0;
        result = ac;
        carry  = 1'b0;
        case (op)
            OP_AND: result = ac & dr;
            OP_ADD: begin
                sum             = {1'b0, ac} + {1'b0, dr};
                {carry, result} = sum;
            end
            // Two's-complement subtract: carry out of 1 means no borrow.
            OP_SUB: begin
                sum             = {1'b0, ac} + {1'b0, ~dr} + ONE;
                {carry, result} = sum;
            end
            OP_LDA: result = dr;
            default: result = ac;
        endcase
    end
endmodule

// File: rtl/cpu_core_param.sv
// Multi-cycle accumulator core: fetch/decode/indirect/execute FSM driving one
// request/ready memory port, with debug views of PC, AC, E and FSM state.
module cpu_core_param
    import cpu_param_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    cpu_core_param_if.master mem,
    output logic             halted,
    output logic [AW-1:0]    pc_out,
    output logic [DW-1:0]    ac_out,
    output logic             e_out,
    output state_t           state_dbg
);
    localparam int          I_POS  = ind_bit(DW);
    localparam int          OP_LSB = op_lsb(DW);
    localparam logic [AW-1:0] PC_ONE = 1;

    state_t        state;
    logic [AW-1:0] pc, ar;
    logic [DW-1:0] ir, dr, ac;
    logic          e, req, we;

    opcode_t       op;
    state_t        tgt;
    logic          tgt_req, tgt_we, tgt_halt;
    logic [DW-1:0] alu_result;
    logic          alu_carry;

    assign op       = opcode_t'(ir[OP_LSB +: 3]);
    assign tgt      = op_target(op);
    assign tgt_req  = (tgt == READ) || (tgt == STORE);
    assign tgt_we   = (tgt == STORE);
    assign tgt_halt = (tgt == HALT);

    cpu_alu #(.DW(DW)) u_alu (
        .ac(ac), .dr(dr), .op(op), .result(alu_result), .carry(alu_carry)
    );

    // mem_req/mem_we are registered and set on entry to a memory state, so the
    // request is already stable in the first cycle of that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= F_ADDR;
            pc     <= '0;
            ar     <= '0;
            ir     <= '0;
            dr     <= '0;
            ac     <= '0;
            e      <= 1'b0;
            req    <= 1'b0;
            we     <= 1'b0;
            halted <= 1'b0;
        end else begin
            case (state)
                F_ADDR: begin
                    ar    <= pc;
                    req   <= 1'b1;
                    we    <= 1'b0;
                    state <= FETCH;
                end
                FETCH: if (mem.mem_ready) begin
                    ir    <= mem.mem_rdata;
                    pc    <= pc + PC_ONE;
                    req   <= 1'b0;
                    state <= DECODE;
                end
                DECODE: begin
                    ar <= ir[AW-1:0];
                    // HLT halts immediately even when its indirect bit is set.
                    if (ir[I_POS] && op != OP_HLT) begin
                        req   <= 1'b1;
                        we    <= 1'b0;
                        state <= INDIR;
                    end else begin
                        req    <= tgt_req;
                        we     <= tgt_we;
                        halted <= tgt_halt;
                        state  <= tgt;
                    end
                end
                INDIR: if (mem.mem_ready) begin
                    ar     <= mem.mem_rdata[AW-1:0];
                    req    <= tgt_req;
                    we     <= tgt_we;
                    halted <= tgt_halt;
                    state  <= tgt;
                end
                READ: if (mem.mem_ready) begin
                    dr    <= mem.mem_rdata;
                    req   <= 1'b0;
                    state <= ALU;
                end
                ALU: begin
                    ac <= alu_result;
                    if (op == OP_ADD || op == OP_SUB) e <= alu_carry;
                    state <= F_ADDR;
                end
                STORE: if (mem.mem_ready) begin
                    req   <= 1'b0;
                    we    <= 1'b0;
                    state <= F_ADDR;
                end
                EXEC_J: begin
                    if (op == OP_JMP || ac == '0) pc <= ar;
                    state <= F_ADDR;
                end
                HALT: begin
                    halted <= 1'b1;
                    state  <= HALT;
                end
                default: state <= F_ADDR;
            endcase
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = ar;
    assign mem.mem_wdata = ac;

    assign pc_out    = pc;
    assign ac_out    = ac;
    assign e_out     = e;
    assign state_dbg = state;
endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param (DW=8, AW=4): directed programs plus random programs,
// all checked against an instruction-level model of the machine.
module tb_cpu_core_param;
    import cpu_param_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_core_param_if #(.DW(8), .AW(4)) bus();

    logic       halted;
    logic [3:0] pc_out;
    logic [7:0] ac_out;
    logic       e_out;
    state_t     state_dbg;

    cpu_core_param #(.DW(8), .AW(4)) dut (
        .clk(clk), .reset(reset), .mem(bus), .halted(halted),
        .pc_out(pc_out), .ac_out(ac_out), .e_out(e_out), .state_dbg(state_dbg)
    );

    logic [7:0] mem  [16];
    logic [7:0] prog [16];
    logic [7:0] mm   [16];
    assign bus.mem_rdata = mem[bus.mem_addr];

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    logic [11:0] m_wq[$];
    int checks = 0;
    int errors = 0;
    int m_ac, m_e, m_pc, m_cyc;
    bit m_halt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_run();
        int pc, ac, e, ir, op, a, ea, opd, k;
        mm = prog;
        m_wq.delete();
        pc = 0; ac = 0; e = 0; k = 0;
        m_cyc = 0; m_halt = 0;
        while (!m_halt && k < 64) begin
            k++;
            ir = int'(mm[pc]);
            pc = (pc + 1) % 16;
            op = (ir / 16) % 8;
            a  = ir % 16;
            if (op == 7) begin
                m_cyc += 3;
                m_halt = 1;
            end else begin
                ea = a;
                m_cyc += (op >= 4) ? 4 : 5;
                if (ir >= 128) begin
                    ea = int'(mm[a]) % 16;
                    m_cyc++;
                end
                opd = int'(mm[ea]);
                case (op)
                    0: ac = ac & opd;
                    1: begin ac = ac + opd; e = ac / 256; ac = ac % 256; end
                    2: begin e = (ac >= opd) ? 1 : 0; ac = (ac - opd + 256) % 256; end
                    3: ac = opd;
                    4: begin mm[ea] = 8'(ac); m_wq.push_back({4'(ea), 8'(ac)}); end
                    5: pc = ea;
                    default: if (ac == 0) pc = ea;
                endcase
            end
        end
        m_ac = ac; m_e = e; m_pc = pc;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: the transfer that will complete at this edge is decided from
    // signals sampled at the preceding negedge.
    task automatic cycle();
        logic       do_wr;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [12:0] expv;
        do_wr = bus.mem_req && bus.mem_ready && bus.mem_we && !reset;
        wa    = bus.mem_addr;
        wd    = bus.mem_wdata;
        @(posedge clk);
        if (do_wr) begin
            mem[wa] = wd;
            expv = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 13'h0;
            check("mem_write", 32'({1'b1, wa, wd}), 32'(expv));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic clear_prog();
        foreach (prog[i]) prog[i] = 8'h00;
    endtask

    task automatic start_prog();
        model_run();
        mem   = prog;
        exp_q = m_wq;
        bus.mem_ready = 1'b1;
        do_reset();
    endtask

    task automatic run_to_halt(input bit rnd_ready, input int budget, output int n);
        n = 0;
        while (!halted && n < budget) begin
            bus.mem_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle();
            n++;
        end
        bus.mem_ready = 1'b1;
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic check_final(input string tag);
        check({tag, "_ac"}, 32'(ac_out), 32'(m_ac));
        check({tag, "_e"}, 32'(e_out), 32'(m_e));
        check({tag, "_pc"}, 32'(pc_out), 32'(m_pc));
        check({tag, "_wr_left"}, 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 16; i++) check({tag, "_mem"}, 32'(mem[i]), 32'(mm[i]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int tries;
        bus.mem_ready = 1'b1;
        @(negedge clk);

        // Reset state
        clear_prog();
        start_prog();
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_ac", 32'(ac_out), 32'd0);
        check("rst_e", 32'(e_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(F_ADDR));

        // Basic program: LDA 8, ADD 9, STA A, HLT
        clear_prog();
        prog[0] = 8'h38; prog[1] = 8'h19; prog[2] = 8'h4A; prog[3] = 8'h70;
        prog[8] = 8'h05; prog[9] = 8'h07;
        start_prog();
        run_to_halt(1'b0, 100, n);
        check("basic_cycles", 32'(n), 32'd17);
        check("basic_memA", 32'(mem[10]), 32'h0C);
        check("basic_pc", 32'(pc_out), 32'd4);
        check_final("basic");

        // ADD overflow
        clear_prog();
        prog[0] = 8'h38; prog[1] = 8'h19; prog[2] = 8'h70;
        prog[8] = 8'hFF; prog[9] = 8'h01;
        start_prog();
        run_to_halt(1'b0, 100, n);
        check("add_ov_ac", 32'(ac_out), 32'h00);
        check("add_ov_e", 32'(e_out), 32'd1);
        check_final("add_ov");

        // SUB borrow after E was set by an overflowing ADD
        clear_prog();
        prog[0] = 8'h3B; prog[1] = 8'h1C; prog[2] = 8'h38; prog[3] = 8'h29; prog[4] = 8'h70;
        prog[8] = 8'h03; prog[9] = 8'h05; prog[11] = 8'hFF; prog[12] = 8'h01;
        start_prog();
        run_to_halt(1'b0, 100, n);
        check("sub_ac", 32'(ac_out), 32'hFE);
        check("sub_e", 32'(e_out), 32'd0);
        check_final("sub");

        // Indirect load: 6-cycle LDA followed by 3-cycle HLT
        clear_prog();
        prog[0] = 8'hBC; prog[1] = 8'h70; prog[12] = 8'h0D; prog[13] = 8'h04;
        start_prog();
        run_to_halt(1'b0, 100, n);
        check("ind_ac", 32'(ac_out), 32'h04);
        check("ind_cycles", 32'(n), 32'd9);
        check_final("ind");

        // JZ taken with AC=0
        clear_prog();
        prog[0] = 8'h66; prog[6] = 8'h70;
        start_prog();
        run_to_halt(1'b0, 100, n);
        check("jz_taken_pc", 32'(pc_out), 32'd7);
        check("jz_taken_cycles", 32'(n), 32'd7);

        // JZ not taken with AC=1
        clear_prog();
        prog[0] = 8'h38; prog[1] = 8'h66; prog[2] = 8'h70; prog[6] = 8'h70; prog[8] = 8'h01;
        start_prog();
        run_to_halt(1'b0, 100, n);
        check("jz_not_pc", 32'(pc_out), 32'd3);
        check("jz_not_cycles", 32'(n), 32'd12);

        // JMP F then fetch at F wraps PC
        clear_prog();
        prog[0] = 8'h5F; prog[15] = 8'h70;
        start_prog();
        run_to_halt(1'b0, 100, n);
        check("jmp_wrap_pc", 32'(pc_out), 32'd0);
        check("jmp_wrap_cycles", 32'(n), 32'd7);

        // Wait states during the STA write
        clear_prog();
        prog[0] = 8'h38; prog[1] = 8'h4A; prog[2] = 8'h70; prog[8] = 8'h5A;
        start_prog();
        repeat (8) cycle();
        bus.mem_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            check("wait_req", 32'(bus.mem_req), 32'd1);
            check("wait_we", 32'(bus.mem_we), 32'd1);
            check("wait_addr", 32'(bus.mem_addr), 32'hA);
            check("wait_wdata", 32'(bus.mem_wdata), 32'h5A);
            cycle();
        end
        check("wait_no_early_write", 32'(mem[10]), 32'h00);
        bus.mem_ready = 1'b1;
        check("wait_final_addr", 32'(bus.mem_addr), 32'hA);
        run_to_halt(1'b0, 100, n);
        check("wait_cycles", 32'(n + 11), 32'd15);
        check_final("wait");

        // Reset mid-READ with mem_ready low
        clear_prog();
        prog[0] = 8'h38; prog[1] = 8'h39; prog[2] = 8'h70; prog[8] = 8'h77; prog[9] = 8'h21;
        start_prog();
        repeat (5) cycle();
        check("mid_ac_before", 32'(ac_out), 32'h77);
        repeat (3) cycle();
        bus.mem_ready = 1'b0;
        cycle();
        check("mid_read_pending", 32'({bus.mem_req, bus.mem_we, bus.mem_addr}), 32'h29);
        reset = 1'b1;
        cycle();
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_bus", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'd0);
        check("mid_rst_dbg", 32'({halted, pc_out, ac_out, e_out}), 32'd0);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        cycle();
        check("mid_restart_fetch", 32'({bus.mem_req, bus.mem_we, bus.mem_addr}), 32'h20);
        run_to_halt(1'b0, 100, n);
        check("mid_cycles", 32'(n + 1), 32'(m_cyc));
        check_final("mid");

        // Random programs against the model; odd runs insert random wait states
        for (int r = 0; r < 24; r++) begin
            tries = 0;
            do begin
                for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
                model_run();
                tries++;
            end while (!m_halt && tries < 500);
            if (!m_halt) begin
                clear_prog();
                prog[0] = 8'h70;
            end
            start_prog();
            run_to_halt(r[0], 4000, n);
            if (!r[0]) check("rand_cycles", 32'(n), 32'(m_cyc));
            check_final("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
